// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter sharing one external combinational adder among NUM_REQ requesters
// Optional result checker enabled by defining ADDER_SHARE_ARBITER_CHECK_EN (adds chk_err / chk_err_req).
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_in1,
  input  logic [NUM_REQ*WIDTH-1:0]   req_in0,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_carry,
  output logic [WIDTH-1:0]           add_in1,
  output logic [WIDTH-1:0]           add_in0,
  input  logic [WIDTH-1:0]           add_sum,
  input  logic                       add_carry
`ifdef ADDER_SHARE_ARBITER_CHECK_EN
  ,
  output logic                       chk_err,
  output logic [$clog2(NUM_REQ)-1:0] chk_err_req
`endif
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   add_in1_q, add_in1_d;
  logic [WIDTH-1:0]   add_in0_q, add_in0_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic               win_found;
  logic [GW-1:0]      win_idx;

`ifdef ADDER_SHARE_ARBITER_CHECK_EN
  logic               chk_err_q, chk_err_d;
  logic [GW-1:0]      chk_err_req_q, chk_err_req_d;
  logic [WIDTH:0]     chk_expect;
`endif

  // Round-robin search: first valid requester after the last one served, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int            s;
      logic [GW-1:0] cand;
      s = int'(last_grant_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      cand = s[GW-1:0];
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Accept is offered only while idle, to the round-robin winner alone.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && win_found) req_ready[win_idx] = 1'b1;
  end

  // Next-state and datapath updates for the IDLE -> ISSUE -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    add_in1_d    = add_in1_q;
    add_in0_d    = add_in0_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_valid_d  = rsp_valid_q;
`ifdef ADDER_SHARE_ARBITER_CHECK_EN
    chk_err_d     = chk_err_q;
    chk_err_req_d = chk_err_req_q;
    chk_expect    = {1'b0, add_in1_q} + {1'b0, add_in0_q};
`endif
    case (state_q)
      S_IDLE: begin
        // req_ready[win_idx] is high whenever win_found, so a found winner is an accept.
        if (win_found) begin
          grant_d   = win_idx;
          add_in1_d = req_in1[win_idx*WIDTH +: WIDTH];
          add_in0_d = req_in0[win_idx*WIDTH +: WIDTH];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The adder has had a full cycle on stable operands; capture its result.
        rsp_sum_d            = add_sum;
        rsp_carry_d          = add_carry;
        rsp_valid_d          = '0;
        rsp_valid_d[grant_q] = 1'b1;
        state_d              = S_RESP;
`ifdef ADDER_SHARE_ARBITER_CHECK_EN
        if ({add_carry, add_sum} != chk_expect) begin
          chk_err_d = 1'b1;
          if (!chk_err_q) chk_err_req_d = grant_q;
        end
`endif
      end
      S_RESP: begin
        // Only the granted requester's rsp_ready matters; hold everything until it accepts.
        if (rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          rsp_valid_d  = '0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation and restarts priority at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      add_in1_q    <= '0;
      add_in0_q    <= '0;
      rsp_sum_q    <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_valid_q  <= '0;
`ifdef ADDER_SHARE_ARBITER_CHECK_EN
      chk_err_q     <= 1'b0;
      chk_err_req_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      add_in1_q    <= add_in1_d;
      add_in0_q    <= add_in0_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_valid_q  <= rsp_valid_d;
`ifdef ADDER_SHARE_ARBITER_CHECK_EN
      chk_err_q     <= chk_err_d;
      chk_err_req_q <= chk_err_req_d;
`endif
    end
  end

  assign add_in1   = add_in1_q;
  assign add_in0   = add_in0_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_valid = rsp_valid_q;
`ifdef ADDER_SHARE_ARBITER_CHECK_EN
  assign chk_err     = chk_err_q;
  assign chk_err_req = chk_err_req_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter (NUM_REQ=4, WIDTH=8)
module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_in1 = '0;
  logic [N*W-1:0] req_in0 = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '1;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;
  logic [W-1:0]   add_in1;
  logic [W-1:0]   add_in0;
  logic [W-1:0]   add_sum;
  logic           add_carry;
`ifdef ADDER_SHARE_ARBITER_CHECK_EN
  logic           chk_err;
  logic [1:0]     chk_err_req;
`endif

  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  m_last = N - 1;
  int  prev_acc = 0;
  int  wait_ops [N];
  bit  fault_en = 1'b0;

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in0(req_in0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .add_in1(add_in1), .add_in0(add_in0),
    .add_sum(add_sum), .add_carry(add_carry)
`ifdef ADDER_SHARE_ARBITER_CHECK_EN
    , .chk_err(chk_err), .chk_err_req(chk_err_req)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External adder, with an optional planted fault for 0x05+0x03.
  always_comb begin
    if (fault_en && add_in1 == 8'h05 && add_in0 == 8'h03) {add_carry, add_sum} = 9'h000;
    else {add_carry, add_sum} = {1'b0, add_in1} + {1'b0, add_in0};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: first valid requester after m_last, modulo N.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic raise(input int i, input int a, input int b);
    req_valid[i] = 1'b1;
    req_in1[i*W +: W] = 8'(a);
    req_in0[i*W +: W] = 8'(b);
    wait_ops[i] = 0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    @(posedge clk);
    #2 rst = 1'b0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) wait_ops[i] = 0;
  endtask

  // One full operation from IDLE: grant, ISSUE, RESP (with optional backpressure), handshake.
  task automatic serve(input int hold, input bit keep, input bit spacing);
    int g;
    int e;
    logic [7:0] a, b;
    @(negedge clk);
    g = pick(req_valid, m_last);
    check("req_ready_idle", 32'(req_ready), (g < 0) ? 0 : (1 << g));
    if (g < 0) return;
    a = req_in1[g*W +: W];
    b = req_in0[g*W +: W];
    e = (fault_en && a == 8'h05 && b == 8'h03) ? 0 : int'(a) + int'(b);
    check("fairness", 32'(wait_ops[g] <= N), 1);
    for (int i = 0; i < N; i++) if (i != g && req_valid[i]) wait_ops[i]++;
    wait_ops[g] = 0;
    @(posedge clk);
    #1;
    if (spacing) check("op_spacing", cyc - prev_acc, 3);
    prev_acc = cyc;
    if (keep) raise(g, $urandom_range(0, 255), $urandom_range(0, 255));
    else req_valid[g] = 1'b0;
    rsp_ready = (hold > 0) ? (4'hF & ~(4'(1) << g)) : 4'hF;
    @(negedge clk);
    check("issue_req_ready", 32'(req_ready), 0);
    check("issue_rsp_valid", 32'(rsp_valid), 0);
    check("issue_add_in1", 32'(add_in1), 32'(a));
    check("issue_add_in0", 32'(add_in0), 32'(b));
    @(posedge clk);
    @(negedge clk);
    check("resp_rsp_valid", 32'(rsp_valid), 1 << g);
    check("resp_sum", 32'(rsp_sum), e & 8'hFF);
    check("resp_carry", 32'(rsp_carry), e >> 8);
    check("resp_add_in1", 32'(add_in1), 32'(a));
    check("resp_add_in0", 32'(add_in0), 32'(b));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 1 << g);
      check("hold_rsp_sum", 32'(rsp_sum), e & 8'hFF);
      check("hold_req_ready", 32'(req_ready), 0);
      check("hold_add_in1", 32'(add_in1), 32'(a));
    end
    rsp_ready = 4'hF;
    @(posedge clk);
    #1;
    m_last = g;
  endtask

  initial begin
    for (int i = 0; i < N; i++) wait_ops[i] = 0;
    // Reset state
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_sum", 32'(rsp_sum), 0);
    check("rst_rsp_carry", 32'(rsp_carry), 0);
    check("rst_add_in1", 32'(add_in1), 0);
    check("rst_add_in0", 32'(add_in0), 0);
    do_reset();

    // 1: single request on requester 1
    raise(1, 8'h0F, 8'h01);
    serve(0, 0, 0);
    // 2: carry out on requester 0
    raise(0, 8'hFF, 8'h01);
    serve(0, 0, 0);

    // 3: all four continuously requesting -> 0,1,2,3,0 at one op per 3 cycles
    do_reset();
    for (int i = 0; i < N; i++) raise(i, $urandom_range(0, 255), $urandom_range(0, 255));
    serve(0, 1, 0);
    for (int k = 0; k < 4; k++) serve(0, 1, 1);
    check("t3_last_grant", m_last, 0);
    req_valid = '0;

    // 4: backpressure on requester 2 while 3 waits
    raise(2, 8'h80, 8'h80);
    raise(3, 8'h11, 8'h22);
    serve(5, 0, 0);
    serve(0, 0, 0);

    // 5: reset during RESP of requester 3
    raise(3, 8'h33, 8'h44);
    @(negedge clk);
    check("t5_req_ready", 32'(req_ready), 32'h8);
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = '0;
    @(posedge clk);
    @(negedge clk);
    check("t5_resp_valid", 32'(rsp_valid), 32'h8);
    #2 rst = 1'b1;
    #1;
    check("t5_async_rsp_valid", 32'(rsp_valid), 0);
    check("t5_async_rsp_sum", 32'(rsp_sum), 0);
    check("t5_async_add_in1", 32'(add_in1), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    rsp_ready = '1;
    m_last = N - 1;
    raise(0, $urandom_range(0, 255), $urandom_range(0, 255));
    raise(3, $urandom_range(0, 255), $urandom_range(0, 255));
    serve(0, 0, 0);
    check("t5_first_grant", m_last, 0);
    serve(0, 0, 0);

    // Randomized traffic with random backpressure
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) raise(i, $urandom_range(0, 255), $urandom_range(0, 255));
      if (req_valid == '0) raise(int'($urandom_range(0, N - 1)), $urandom_range(0, 255), $urandom_range(0, 255));
      serve(int'($urandom_range(0, 2)), 0, 0);
    end
    req_valid = '0;

`ifdef ADDER_SHARE_ARBITER_CHECK_EN
    // 6: checker flags a faulty adder result on requester 1, sticky until reset
    do_reset();
    check("t6_chk_err_rst", 32'(chk_err), 0);
    fault_en = 1'b1;
    raise(1, 8'h05, 8'h03);
    serve(0, 0, 0);
    fault_en = 1'b0;
    check("t6_chk_err", 32'(chk_err), 1);
    check("t6_chk_err_req", 32'(chk_err_req), 1);
    raise(2, 8'h0A, 8'h14);
    serve(0, 0, 0);
    check("t6_chk_err_sticky", 32'(chk_err), 1);
    check("t6_chk_err_req_sticky", 32'(chk_err_req), 1);
    do_reset();
    check("t6_chk_err_cleared", 32'(chk_err), 0);
    check("t6_chk_err_req_cleared", 32'(chk_err_req), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
